// File: rtl/scaler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scaler_pkg
//  Description : Shared widths, display defaults and FSM encoding for the
//                scaler zoom control path.
//  Revision    : 1.0 - initial release
// ============================================================================
package scaler_pkg;

    localparam int DIM_W      = 12;
    localparam int LVL_W      = 4;
    localparam int H_DISP_DEF = 1280;
    localparam int V_DISP_DEF = 720;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } zoom_state_t;

endpackage : scaler_pkg
`default_nettype wire

// File: rtl/scaler_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scaler_frame_timer
//  Description : Counts frame_flag pulses while ramping and strobes a level
//                step every RAMP_FRAMES frames; the first step of a ramp is
//                taken on the first frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module scaler_frame_timer #(
    parameter int RAMP_FRAMES = 2
) (
    input  logic pix_clk,
    input  logic rst,
    input  logic i_frame_flag,
    input  logic i_run,
    input  logic i_hold,
    output logic o_step
);

    localparam int CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(RAMP_FRAMES - 1);

    logic [CNT_W-1:0] r_frm_cnt;
    logic [CNT_W-1:0] w_cnt_eff;

    // While idle the count is treated as already expired so that the very
    // first frame of a new ramp (even a coincident one) takes a step.
    assign w_cnt_eff = i_hold ? c_LAST : r_frm_cnt;
    assign o_step    = i_frame_flag && i_run && (w_cnt_eff == c_LAST);

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            r_frm_cnt <= '0;
        end else if (i_frame_flag && i_run) begin
            r_frm_cnt <= o_step ? '0 : w_cnt_eff + 1'b1;
        end else if (i_hold) begin
            r_frm_cnt <= c_LAST;
        end
    end

endmodule : scaler_frame_timer
`default_nettype wire

// File: rtl/scaler_zoom_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scaler_zoom_ctrl
//  Description : Frame-synchronous zoom sequencer; turns zoom commands into a
//                target level and ramps t_width/t_height one level per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module scaler_zoom_ctrl
    import scaler_pkg::*;
#(
    parameter int H_DISP      = H_DISP_DEF,
    parameter int V_DISP      = V_DISP_DEF,
    parameter int H_STEP      = 64,
    parameter int V_STEP      = 36,
    parameter int MAX_LEVEL   = 8,
    parameter int RAMP_FRAMES = 2
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             frame_flag,
    input  logic             zoom_in,
    input  logic             zoom_out,
    input  logic             zoom_home,
    output logic [DIM_W-1:0] t_width,
    output logic [DIM_W-1:0] t_height,
    output logic             scale_state,
    output logic [LVL_W-1:0] cur_level,
    output logic             busy
);

    localparam logic [LVL_W-1:0] c_MAX_LVL = LVL_W'(MAX_LEVEL);
    localparam logic [DIM_W-1:0] c_H_DISP  = DIM_W'(H_DISP);
    localparam logic [DIM_W-1:0] c_V_DISP  = DIM_W'(V_DISP);
    localparam logic [DIM_W-1:0] c_H_STEP  = DIM_W'(H_STEP);
    localparam logic [DIM_W-1:0] c_V_STEP  = DIM_W'(V_STEP);

    zoom_state_t      r_state;
    logic [LVL_W-1:0] r_target;
    logic [LVL_W-1:0] w_target_nxt;
    logic [LVL_W-1:0] w_cur_step;
    logic             w_up;
    logic             w_run;
    logic             w_step;

    // Commands land in the target this cycle; stepping below already sees it.
    always_comb begin
        w_target_nxt = r_target;
        if (zoom_home) begin
            w_target_nxt = '0;
        end else if (zoom_in && !zoom_out && (r_target != c_MAX_LVL)) begin
            w_target_nxt = r_target + 1'b1;
        end else if (zoom_out && !zoom_in && (r_target != '0)) begin
            w_target_nxt = r_target - 1'b1;
        end
    end

    assign w_run      = (w_target_nxt != cur_level);
    assign w_up       = (w_target_nxt > cur_level);
    assign w_cur_step = w_up ? cur_level + 1'b1 : cur_level - 1'b1;

    scaler_frame_timer #(
        .RAMP_FRAMES (RAMP_FRAMES)
    ) u_frame_timer (
        .pix_clk      (pix_clk),
        .rst          (rst),
        .i_frame_flag (frame_flag),
        .i_run        (w_run),
        .i_hold       (r_state == ST_IDLE),
        .o_step       (w_step)
    );

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            cur_level   <= '0;
            t_width     <= c_H_DISP;
            t_height    <= c_V_DISP;
            scale_state <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_target <= w_target_nxt;
            if (w_step) begin
                cur_level   <= w_cur_step;
                t_width     <= w_up ? t_width + c_H_STEP : t_width - c_H_STEP;
                t_height    <= w_up ? t_height + c_V_STEP : t_height - c_V_STEP;
                scale_state <= (w_cur_step != '0);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_run && !(w_step && (w_cur_step == w_target_nxt))) begin
                        r_state <= ST_RAMP;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_RAMP: begin
                    if (!w_run || (w_step && (w_cur_step == w_target_nxt))) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : scaler_zoom_ctrl
`default_nettype wire

// File: tb/tb_scaler_zoom_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scaler_zoom_ctrl
//  Description : Self-checking bench for scaler_zoom_ctrl against a
//                frame-level behavioural model of the zoom sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scaler_zoom_ctrl;

    localparam int H_DISP = 1280;
    localparam int V_DISP = 720;
    localparam int H_STEP = 64;
    localparam int V_STEP = 36;
    localparam int MAX_LV = 8;
    localparam int RF     = 2;

    logic        pix_clk = 1'b0;
    logic        rst;
    logic        frame_flag;
    logic        zoom_in;
    logic        zoom_out;
    logic        zoom_home;
    logic [11:0] t_width;
    logic [11:0] t_height;
    logic        scale_state;
    logic [3:0]  cur_level;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: target level, presented level, frames left before next step.
    int  m_tgt;
    int  m_cur;
    int  m_left;
    bit  m_busy;

    always #5 pix_clk = ~pix_clk;

    scaler_zoom_ctrl #(
        .H_DISP      (H_DISP),
        .V_DISP      (V_DISP),
        .H_STEP      (H_STEP),
        .V_STEP      (V_STEP),
        .MAX_LEVEL   (MAX_LV),
        .RAMP_FRAMES (RF)
    ) dut (
        .pix_clk     (pix_clk),
        .rst         (rst),
        .frame_flag  (frame_flag),
        .zoom_in     (zoom_in),
        .zoom_out    (zoom_out),
        .zoom_home   (zoom_home),
        .t_width     (t_width),
        .t_height    (t_height),
        .scale_state (scale_state),
        .cur_level   (cur_level),
        .busy        (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("width",  int'(t_width),     H_DISP + m_cur * H_STEP);
        chk("height", int'(t_height),    V_DISP + m_cur * V_STEP);
        chk("scale",  int'(scale_state), (m_cur != 0) ? 1 : 0);
        chk("level",  int'(cur_level),   m_cur);
        chk("busy",   int'(busy),        m_busy ? 1 : 0);
    endtask

    task automatic model_reset();
        m_tgt  = 0;
        m_cur  = 0;
        m_left = 1;
        m_busy = 1'b0;
    endtask

    task automatic cycle(input bit ff, input bit zi, input bit zo, input bit zh);
        @(negedge pix_clk);
        frame_flag = ff;
        zoom_in    = zi;
        zoom_out   = zo;
        zoom_home  = zh;
        @(posedge pix_clk);
        if (zh)                          m_tgt = 0;
        else if (zi && !zo && m_tgt < MAX_LV) m_tgt = m_tgt + 1;
        else if (zo && !zi && m_tgt > 0) m_tgt = m_tgt - 1;
        if (ff && m_tgt != m_cur) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_cur  = (m_tgt > m_cur) ? m_cur + 1 : m_cur - 1;
                m_left = RF;
            end
        end
        m_busy = (m_tgt != m_cur);
        if (!m_busy) m_left = 1;
        #1;
        check_model();
        frame_flag = 1'b0;
        zoom_in    = 1'b0;
        zoom_out   = 1'b0;
        zoom_home  = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic async_reset();
        @(negedge pix_clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model();
        @(negedge pix_clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_flag = 1'b0; zoom_in = 1'b0; zoom_out = 1'b0; zoom_home = 1'b0;
        model_reset();
        repeat (3) @(posedge pix_clk);
        #1 check_model();
        @(negedge pix_clk);
        rst = 1'b0;

        // Idle frames leave the native size untouched.
        run_frames(3);
        chk("t1_width", int'(t_width), 1280);

        // Two zoom-in commands, two-frame ramp per level.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_busy", int'(busy), 1);
        run_frames(1);
        chk("t2_w1", int'(t_width), 1344);
        chk("t2_h1", int'(t_height), 756);
        run_frames(2);
        chk("t2_w2", int'(t_width), 1408);
        chk("t2_h2", int'(t_height), 792);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_idle", int'(busy), 0);

        // Saturate at the top level.
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_frames(14);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_frames(3);
        chk("t3_width", int'(t_width), 1792);
        chk("t3_height", int'(t_height), 1008);

        // Opposing commands cancel; home from level 5 ramps back to native.
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(7);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        run_frames(3);
        chk("t4_lvl5", int'(cur_level), 5);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(10);
        chk("t4_lvl0", int'(cur_level), 0);
        chk("t4_scale", int'(scale_state), 0);

        // Command coincident with frame_flag steps on that very frame.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_lvl", int'(cur_level), 1);

        // Reset in the middle of a ramp at level 3.
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !(m_cur == 3 && m_busy); i++) begin
            cycle((i % 4) == 3, 1'b0, 1'b0, 1'b0);
        end
        chk("t6_pre", int'(cur_level), 3);
        async_reset();
        chk("t6_width", int'(t_width), 1280);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 4) == 0,
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 11) == 0,
                      $urandom_range(0, 79) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_scaler_zoom_ctrl
`default_nettype wire
